eq32_scoreboard: RTL and testbench

Synthesizable response checker for the 32-bit equality comparator. It receives a stream of comparator transactions (operands X, Y and the comparator's observed output Z) over a valid/ready handshake. For each one it computes the expected result X == Y, counts checks and mismatches, and captures the first failing vector. It is the receiving end of the comparator's stimulus path and sits beside the eq32 instance in on-chip self-test builds, replacing the simulation-only checker.

---
 rtl/eq32_scoreboard_if.sv | 13 +
 rtl/eq32_scoreboard.sv | 135 +++++++++++++
 tb/tb_eq32_scoreboard.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eq32_scoreboard_if.sv
// Transaction channel into the eq32 response checker: operands X/Y and the
// comparator's observed output Z, moved with a valid/ready handshake.
// Ports: in_valid, X, Y, Z (master -> slave); in_ready (slave -> master).
interface eq32_scoreboard_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] X;
  logic [31:0] Y;
  logic        Z;

  modport master (output in_valid, output X, output Y, output Z, input in_ready);
  modport slave  (input in_valid, input X, input Y, input Z, output in_ready);
endinterface

// File: rtl/eq32_scoreboard.sv
// Purpose: checks eq32 comparator responses (Z against X == Y), counts checks
//   and mismatches, captures the first failing vector.
// Latency: accepted at edge N, committed to counters/flags/capture at edge N+1.
// Backpressure: in_ready = RUN && !clear; 1 txn/cycle sustained, drops to 0 in HALT.
// Ports: clk, rst_n (async active-low), clear (sync, highest priority),
//   in_if (slave: in_valid/in_ready/X/Y/Z), check_count, err_count, err_flag,
//   first_x, first_y, first_z, halted.
module eq32_scoreboard #(
  parameter int CW          = 16,
  parameter int STOP_ON_ERR = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  eq32_scoreboard_if.slave     in_if,
  output logic [CW-1:0]        check_count,
  output logic [CW-1:0]        err_count,
  output logic                 err_flag,
  output logic [31:0]          first_x,
  output logic [31:0]          first_y,
  output logic                 first_z,
  output logic                 halted
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  localparam logic [CW-1:0] CNT_MAX = '1;

  state_t      state_q;
  state_t      state_d;

  logic        s1_vld;
  logic [31:0] s1_x;
  logic [31:0] s1_y;
  logic        s1_z;

  logic        accept;
  logic        commit_err;

  // Ready never looks at in_valid, so the source may wait on ready safely.
  assign in_if.in_ready = (state_q == RUN) && !clear;
  assign accept         = in_if.in_valid && in_if.in_ready;

  // Mismatch of the transaction sitting in stage 1 (only meaningful when s1_vld).
  assign commit_err     = s1_vld && (s1_z != (s1_x == s1_y));

  assign halted         = (state_q == HALT);

  // ---------------------------------------------------------------------------
  // State machine
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN:     if (commit_err && (STOP_ON_ERR != 0)) state_d = HALT;
        HALT:    state_d = HALT;
        default: state_d = RUN;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: capture the accepted transaction
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_x   <= '0;
      s1_y   <= '0;
      s1_z   <= 1'b0;
    end else if (clear) begin
      s1_vld <= 1'b0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_x <= in_if.X;
        s1_y <= in_if.Y;
        s1_z <= in_if.Z;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: commit into counters, sticky flag and first-failure capture.
  // A transaction left in stage 1 when HALT is entered still commits here;
  // the capture registers are protected by the err_flag test, not by state.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      check_count <= '0;
      err_count   <= '0;
      err_flag    <= 1'b0;
      first_x     <= '0;
      first_y     <= '0;
      first_z     <= 1'b0;
    end else if (clear) begin
      check_count <= '0;
      err_count   <= '0;
      err_flag    <= 1'b0;
      first_x     <= '0;
      first_y     <= '0;
      first_z     <= 1'b0;
    end else if (s1_vld) begin
      if (check_count != CNT_MAX) begin
        check_count <= check_count + CW'(1);
      end
      if (commit_err) begin
        if (err_count != CNT_MAX) begin
          err_count <= err_count + CW'(1);
        end
        err_flag <= 1'b1;
        if (!err_flag) begin
          first_x <= s1_x;
          first_y <= s1_y;
          first_z <= s1_z;
        end
      end
    end
  end

endmodule

// File: tb/tb_eq32_scoreboard.sv
// Drives one transaction stream into three scoreboards in parallel:
//   dut0 stops on error (CW=16), dut1 keeps running (CW=16), dut2 keeps running (CW=2).
// Each is checked every cycle against a transaction-level reference model.
module tb_eq32_scoreboard;

  logic clk;
  logic rst_n;
  logic clear;

  logic        t_valid;
  logic [31:0] t_x;
  logic [31:0] t_y;
  logic        t_z;

  int checks;
  int failures;

  eq32_scoreboard_if if0 ();
  eq32_scoreboard_if if1 ();
  eq32_scoreboard_if if2 ();

  assign if0.in_valid = t_valid;
  assign if0.X        = t_x;
  assign if0.Y        = t_y;
  assign if0.Z        = t_z;
  assign if1.in_valid = t_valid;
  assign if1.X        = t_x;
  assign if1.Y        = t_y;
  assign if1.Z        = t_z;
  assign if2.in_valid = t_valid;
  assign if2.X        = t_x;
  assign if2.Y        = t_y;
  assign if2.Z        = t_z;

  logic [15:0] a_chk, a_err, b_chk, b_err;
  logic [1:0]  c_chk, c_err;
  logic        a_flag, b_flag, c_flag;
  logic [31:0] a_fx, a_fy, b_fx, b_fy, c_fx, c_fy;
  logic        a_fz, b_fz, c_fz;
  logic        a_halt, b_halt, c_halt;

  eq32_scoreboard #(.CW(16), .STOP_ON_ERR(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_if(if0),
    .check_count(a_chk), .err_count(a_err), .err_flag(a_flag),
    .first_x(a_fx), .first_y(a_fy), .first_z(a_fz), .halted(a_halt));

  eq32_scoreboard #(.CW(16), .STOP_ON_ERR(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_if(if1),
    .check_count(b_chk), .err_count(b_err), .err_flag(b_flag),
    .first_x(b_fx), .first_y(b_fy), .first_z(b_fz), .halted(b_halt));

  eq32_scoreboard #(.CW(2), .STOP_ON_ERR(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_if(if2),
    .check_count(c_chk), .err_count(c_err), .err_flag(c_flag),
    .first_x(c_fx), .first_y(c_fy), .first_z(c_fz), .halted(c_halt));

  // Observed outputs gathered per instance, zero-extended for comparison.
  logic [63:0] o_rdy [3];
  logic [63:0] o_chk [3];
  logic [63:0] o_err [3];
  logic [63:0] o_flag[3];
  logic [63:0] o_fx  [3];
  logic [63:0] o_fy  [3];
  logic [63:0] o_fz  [3];
  logic [63:0] o_halt[3];

  assign o_rdy[0]  = 64'(if0.in_ready);
  assign o_rdy[1]  = 64'(if1.in_ready);
  assign o_rdy[2]  = 64'(if2.in_ready);
  assign o_chk[0]  = 64'(a_chk);
  assign o_chk[1]  = 64'(b_chk);
  assign o_chk[2]  = 64'(c_chk);
  assign o_err[0]  = 64'(a_err);
  assign o_err[1]  = 64'(b_err);
  assign o_err[2]  = 64'(c_err);
  assign o_flag[0] = 64'(a_flag);
  assign o_flag[1] = 64'(b_flag);
  assign o_flag[2] = 64'(c_flag);
  assign o_fx[0]   = 64'(a_fx);
  assign o_fx[1]   = 64'(b_fx);
  assign o_fx[2]   = 64'(c_fx);
  assign o_fy[0]   = 64'(a_fy);
  assign o_fy[1]   = 64'(b_fy);
  assign o_fy[2]   = 64'(c_fy);
  assign o_fz[0]   = 64'(a_fz);
  assign o_fz[1]   = 64'(b_fz);
  assign o_fz[2]   = 64'(c_fz);
  assign o_halt[0] = 64'(a_halt);
  assign o_halt[1] = 64'(b_halt);
  assign o_halt[2] = 64'(c_halt);

  // Reference model: per instance, a transaction-level view of the checker.
  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        z;
  } txn_t;

  int          m_stop[3] = '{1, 0, 0};
  int          m_max [3] = '{65535, 65535, 3};
  txn_t        m_pend[3][$];
  int          m_chk [3];
  int          m_err [3];
  bit          m_flag[3];
  logic [31:0] m_fx  [3];
  logic [31:0] m_fy  [3];
  logic        m_fz  [3];
  bit          m_halt[3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_pend[i].delete();
      m_chk[i]  = 0;
      m_err[i]  = 0;
      m_flag[i] = 1'b0;
      m_fx[i]   = '0;
      m_fy[i]   = '0;
      m_fz[i]   = 1'b0;
      m_halt[i] = 1'b0;
    end
  endtask

  task automatic chk(string tag, int i, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, i, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk("check_count", i, o_chk[i],  64'(m_chk[i]));
      chk("err_count",   i, o_err[i],  64'(m_err[i]));
      chk("err_flag",    i, o_flag[i], 64'(m_flag[i]));
      chk("first_x",     i, o_fx[i],   64'(m_fx[i]));
      chk("first_y",     i, o_fy[i],   64'(m_fy[i]));
      chk("first_z",     i, o_fz[i],   64'(m_fz[i]));
      chk("halted",      i, o_halt[i], 64'(m_halt[i]));
    end
  endtask

  // One clock cycle: present inputs, check ready, advance model, clock, check outputs.
  task automatic step(bit v, logic [31:0] x, logic [31:0] y, bit z, bit clr);
    txn_t t;
    bit   acc;
    bit   bad;
    t_valid = v;
    t_x     = x;
    t_y     = y;
    t_z     = z;
    clear   = clr;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("in_ready", i, o_rdy[i], 64'(!m_halt[i] && !clr));
    end
    for (int i = 0; i < 3; i++) begin
      if (clr) begin
        m_pend[i].delete();
        m_chk[i]  = 0;
        m_err[i]  = 0;
        m_flag[i] = 1'b0;
        m_fx[i]   = '0;
        m_fy[i]   = '0;
        m_fz[i]   = 1'b0;
        m_halt[i] = 1'b0;
      end else begin
        acc = v && !m_halt[i];
        if (m_pend[i].size() != 0) begin
          t   = m_pend[i].pop_front();
          bad = (t.z != (t.x == t.y));
          if (m_chk[i] < m_max[i]) m_chk[i]++;
          if (bad) begin
            if (m_err[i] < m_max[i]) m_err[i]++;
            if (!m_flag[i]) begin
              m_fx[i] = t.x;
              m_fy[i] = t.y;
              m_fz[i] = t.z;
            end
            m_flag[i] = 1'b1;
            if (m_stop[i] != 0) m_halt[i] = 1'b1;
          end
        end
        if (acc) begin
          t.x = x;
          t.y = y;
          t.z = z;
          m_pend[i].push_back(t);
        end
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] rx;
    logic [31:0] ry;
    bit          rz;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    clear    = 1'b0;
    t_valid  = 1'b0;
    t_x      = '0;
    t_y      = '0;
    t_z      = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
    #2;

    // Matching operands, back-to-back.
    step(1'b1, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0);
    step(1'b1, 32'h0000_000F, 32'h0000_000F, 1'b1, 1'b0);
    step(1'b1, 32'hFFFF_0000, 32'hFFFF_0000, 1'b1, 1'b0);
    step(1'b1, 32'hF0F0_ABCD, 32'hF0F0_ABCD, 1'b1, 1'b0);
    idle(1);
    chk("four_good_count", 0, o_chk[0], 64'd4);

    // Differing operands correctly reported as not equal.
    step(1'b1, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0);
    step(1'b1, 32'hF000_0000, 32'hE000_0000, 1'b0, 1'b0);
    idle(1);
    chk("six_good_count", 1, o_chk[1], 64'd6);

    // Stop on error: valid held high through and past the bad transaction.
    step(1'b0, '0, '0, 1'b0, 1'b1);
    step(1'b1, 32'h5, 32'h5, 1'b1, 1'b0);
    step(1'b1, 32'h0, 32'h1, 1'b1, 1'b0);
    step(1'b1, 32'h7, 32'h7, 1'b1, 1'b0);
    step(1'b1, 32'h8, 32'h8, 1'b1, 1'b0);
    step(1'b1, 32'h9, 32'h9, 1'b1, 1'b0);
    chk("halt_check_count", 0, o_chk[0], 64'd3);

    // Keep running: two different failures, first capture retained.
    step(1'b0, '0, '0, 1'b0, 1'b1);
    step(1'b1, 32'h0, 32'h1, 1'b1, 1'b0);
    step(1'b1, 32'h3, 32'h3, 1'b0, 1'b0);
    idle(2);
    chk("two_err_count", 1, o_err[1], 64'd2);

    // Clear while halted with a transaction still in stage 1.
    step(1'b0, '0, '0, 1'b0, 1'b1);
    step(1'b1, 32'h0, 32'h1, 1'b1, 1'b0);
    step(1'b1, 32'hA, 32'hA, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    idle(2);

    // Saturation of the narrow counters.
    for (int k = 0; k < 5; k++) step(1'b1, 32'(k), 32'(k + 1), 1'b1, 1'b0);
    idle(2);

    // Asynchronous reset mid-stream discards stage 1.
    step(1'b1, 32'h11, 32'h22, 1'b1, 1'b0);
    t_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    #2;
    rst_n = 1'b1;
    idle(2);

    // Randomised traffic with occasional clears.
    for (int k = 0; k < 400; k++) begin
      rx = $urandom;
      case ($urandom_range(0, 2))
        0:       ry = rx;
        1:       ry = rx ^ (32'h1 << $urandom_range(0, 31));
        default: ry = $urandom;
      endcase
      rz = ($urandom_range(0, 3) == 0) ? !(rx == ry) : (rx == ry);
      step($urandom_range(0, 3) != 0, rx, ry, rz, $urandom_range(0, 24) == 0);
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
